biriscv_fetch_linebuf: RTL and testbench

//  Small direct-mapped instruction line buffer directly upstream of biriscv_frontend.
//  - Serves its 64-bit icache_* fetch interface.
//  - Hits return in 1 cycle at a throughput of one per cycle.
//  - Misses issue an in-order burst line fill on a simple memory read port.
//  - Used on TSN-SoC builds without the full L1 icache.

---
 rtl/biriscv_fetch_linebuf_pkg.sv | 14 +
 rtl/biriscv_fetch_linebuf_if.sv | 38 +++
 rtl/biriscv_fetch_linebuf_ram.sv | 24 ++
 rtl/biriscv_fetch_linebuf.sv | 134 +++++++++++++
 tb/tb_biriscv_fetch_linebuf.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/biriscv_fetch_linebuf_pkg.sv
// Shared definitions for the fetch line buffer: FSM state encodings and beat-count helper.
package biriscv_fetch_linebuf_pkg;

    localparam logic [1:0] LINEBUF_STATE_IDLE = 2'd0;
    localparam logic [1:0] LINEBUF_STATE_REQ  = 2'd1;
    localparam logic [1:0] LINEBUF_STATE_FILL = 2'd2;
    localparam logic [1:0] LINEBUF_STATE_RESP = 2'd3;

    // Number of 64-bit memory beats that make up one line.
    function automatic int unsigned linebuf_beats(input int unsigned line_bytes);
        return line_bytes / 8;
    endfunction

endpackage

// File: rtl/biriscv_fetch_linebuf_if.sv
// Fetch-side (icache_*) and memory-side (mem_*) signal bundle of the line buffer.
interface biriscv_fetch_linebuf_if;
    import biriscv_fetch_linebuf_pkg::*;

    logic        icache_rd_i;
    logic        icache_flush_i;
    logic        icache_invalidate_i;
    logic [31:0] icache_pc_i;
    logic [1:0]  icache_priv_i;
    logic        icache_accept_o;
    logic        icache_valid_o;
    logic        icache_error_o;
    logic [63:0] icache_inst_o;
    logic        icache_page_fault_o;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_accept_i;
    logic        mem_valid_i;
    logic [63:0] mem_data_i;
    logic        mem_error_i;

    // The line buffer itself
    modport slave (
        input  icache_rd_i, icache_flush_i, icache_invalidate_i, icache_pc_i, icache_priv_i,
        output icache_accept_o, icache_valid_o, icache_error_o, icache_inst_o, icache_page_fault_o,
        output mem_rd_o, mem_addr_o,
        input  mem_accept_i, mem_valid_i, mem_data_i, mem_error_i
    );

    // Frontend plus memory environment
    modport master (
        output icache_rd_i, icache_flush_i, icache_invalidate_i, icache_pc_i, icache_priv_i,
        input  icache_accept_o, icache_valid_o, icache_error_o, icache_inst_o, icache_page_fault_o,
        input  mem_rd_o, mem_addr_o,
        output mem_accept_i, mem_valid_i, mem_data_i, mem_error_i
    );

endinterface

// File: rtl/biriscv_fetch_linebuf_ram.sv
// Line data array: flop storage, one synchronous write port, two asynchronous read ports.
module biriscv_fetch_linebuf_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [63:0]   rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [63:0]   rdata_b
);
    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/biriscv_fetch_linebuf.sv
// Direct-mapped instruction line buffer: 1-cycle hits, in-order burst line fill on a miss.
module biriscv_fetch_linebuf
    import biriscv_fetch_linebuf_pkg::*;
#(
    parameter int unsigned LINE_BYTES   = 32,
    parameter int unsigned LINE_BYTES_W = 5,
    parameter int unsigned NUM_LINES    = 4,
    parameter int unsigned NUM_LINES_W  = 2
) (
    input logic                   clk,
    input logic                   rst,
    biriscv_fetch_linebuf_if.slave bus
);
    localparam int unsigned BEATS = linebuf_beats(LINE_BYTES);
    localparam int unsigned CNT_W = (BEATS > 1) ? LINE_BYTES_W - 3 : 1;
    localparam int unsigned AW    = NUM_LINES_W + LINE_BYTES_W - 3;
    localparam int unsigned TAG_W = 32 - LINE_BYTES_W - NUM_LINES_W;
    localparam int unsigned IDX_LO = LINE_BYTES_W;
    localparam int unsigned TAG_LO = LINE_BYTES_W + NUM_LINES_W;

    logic [1:0]             state;
    logic [31:0]            pc_q;
    logic [CNT_W-1:0]       cnt;
    logic                   err_q;
    logic                   drop_q;
    logic [NUM_LINES-1:0]   line_valid;
    logic [TAG_W-1:0]       tags [NUM_LINES];
    logic                   hit_valid_q;
    logic [63:0]            hit_inst_q;

    logic [NUM_LINES_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]       req_tag, fill_tag;
    logic [AW-1:0]          req_addr, fill_raddr, fill_waddr;
    logic [63:0]            hit_data, fill_data;
    logic                   flush, accept, hit, fill_we, last_beat, beat_err;
    logic                   unused_bits;

    assign req_idx    = bus.icache_pc_i[TAG_LO-1:IDX_LO];
    assign req_tag    = bus.icache_pc_i[31:TAG_LO];
    assign req_addr   = bus.icache_pc_i[AW+2:3];
    assign fill_idx   = pc_q[TAG_LO-1:IDX_LO];
    assign fill_tag   = pc_q[31:TAG_LO];
    assign fill_raddr = pc_q[AW+2:3];
    assign fill_waddr = AW'(32'(fill_idx) * BEATS + 32'(cnt));

    assign flush     = bus.icache_flush_i | bus.icache_invalidate_i;
    assign accept    = ~rst & (state == LINEBUF_STATE_IDLE) & ~flush & bus.icache_rd_i;
    assign hit       = line_valid[req_idx] & (tags[req_idx] == req_tag);
    assign fill_we   = (state == LINEBUF_STATE_FILL) & bus.mem_valid_i;
    assign last_beat = fill_we & (cnt == CNT_W'(BEATS - 1));
    assign beat_err  = err_q | bus.mem_error_i;

    biriscv_fetch_linebuf_ram #(
        .DEPTH (NUM_LINES * BEATS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (fill_we),
        .waddr   (fill_waddr),
        .wdata   (bus.mem_data_i),
        .raddr_a (req_addr),
        .rdata_a (hit_data),
        .raddr_b (fill_raddr),
        .rdata_b (fill_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LINEBUF_STATE_IDLE;
            pc_q        <= '0;
            cnt         <= '0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            line_valid  <= '0;
            hit_valid_q <= 1'b0;
            hit_inst_q  <= '0;
        end else begin
            hit_valid_q <= accept & hit;
            if (accept & hit) hit_inst_q <= hit_data;

            case (state)
                LINEBUF_STATE_IDLE: begin
                    if (accept & ~hit) begin
                        pc_q  <= bus.icache_pc_i;
                        state <= LINEBUF_STATE_REQ;
                    end
                end
                LINEBUF_STATE_REQ: begin
                    if (bus.mem_accept_i) begin
                        cnt   <= '0;
                        err_q <= 1'b0;
                        state <= LINEBUF_STATE_FILL;
                    end
                end
                LINEBUF_STATE_FILL: begin
                    if (bus.mem_valid_i) begin
                        cnt   <= cnt + CNT_W'(1);
                        err_q <= beat_err;
                        if (last_beat) begin
                            line_valid[fill_idx] <= ~beat_err & ~drop_q;
                            state                <= LINEBUF_STATE_RESP;
                        end
                    end
                end
                default: begin
                    drop_q <= 1'b0;
                    state  <= LINEBUF_STATE_IDLE;
                end
            endcase

            // Flush wins over a same-edge line install; an in-flight fill is marked to be discarded.
            if (flush) begin
                line_valid <= '0;
                if (state == LINEBUF_STATE_REQ || state == LINEBUF_STATE_FILL) drop_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (last_beat) tags[fill_idx] <= fill_tag;
    end

    assign bus.icache_accept_o     = accept;
    assign bus.icache_valid_o      = hit_valid_q | (state == LINEBUF_STATE_RESP);
    assign bus.icache_error_o      = (state == LINEBUF_STATE_RESP) & err_q;
    assign bus.icache_inst_o       = (state == LINEBUF_STATE_RESP) ? (err_q ? '0 : fill_data)
                                                                   : hit_inst_q;
    assign bus.icache_page_fault_o = 1'b0;
    assign bus.mem_rd_o            = (state == LINEBUF_STATE_REQ);
    assign bus.mem_addr_o          = {pc_q[31:LINE_BYTES_W], {LINE_BYTES_W{1'b0}}};

    assign unused_bits = ^{bus.icache_priv_i, bus.icache_pc_i[2:0], pc_q[2:0]};

endmodule

// File: tb/tb_biriscv_fetch_linebuf.sv
// Directed bench for the fetch line buffer: misses, hits, conflict, error, flush and reset.
module tb_biriscv_fetch_linebuf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [63:0] DA = 64'hA000_0000_0000_0000;
    localparam logic [63:0] DB = 64'hB000_0000_0000_0000;
    localparam logic [63:0] DC = 64'hC000_0000_0000_0000;
    localparam logic [63:0] DE = 64'hE000_0000_0000_0000;
    localparam logic [63:0] DF = 64'hF000_0000_0000_0000;

    biriscv_fetch_linebuf_if bus ();

    biriscv_fetch_linebuf #(
        .LINE_BYTES   (32),
        .LINE_BYTES_W (5),
        .NUM_LINES    (4),
        .NUM_LINES_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one rd at pc; expects it to be accepted and to miss (REQ next cycle).
    task automatic miss_req(input string tag, input logic [31:0] pc, input logic [31:0] line_addr);
        bus.icache_rd_i = 1'b1;
        bus.icache_pc_i = pc;
        #1;
        check({tag, "_accept"}, 64'(bus.icache_accept_o), 64'd1);
        tick();
        bus.icache_rd_i = 1'b0;
        #1;
        check({tag, "_mem_rd"}, 64'(bus.mem_rd_o), 64'd1);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'(line_addr));
    endtask

    // Accept the memory request and return beats base+0..base+3; err_beat<0 means no error.
    task automatic fill(input logic [63:0] base, input int err_beat);
        bus.mem_accept_i = 1'b1;
        tick();
        bus.mem_accept_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_valid_i = 1'b1;
            bus.mem_data_i  = base + 64'(k);
            bus.mem_error_i = (k == err_beat);
            tick();
        end
        bus.mem_valid_i = 1'b0;
        bus.mem_error_i = 1'b0;
        #1;
    endtask

    task automatic check_resp(input string tag, input logic [63:0] inst, input logic err);
        check({tag, "_valid"}, 64'(bus.icache_valid_o), 64'd1);
        check({tag, "_inst"}, bus.icache_inst_o, inst);
        check({tag, "_error"}, 64'(bus.icache_error_o), 64'(err));
        tick();
        check({tag, "_valid_drop"}, 64'(bus.icache_valid_o), 64'd0);
    endtask

    initial begin
        bus.icache_rd_i         = 1'b0;
        bus.icache_flush_i      = 1'b0;
        bus.icache_invalidate_i = 1'b0;
        bus.icache_pc_i         = '0;
        bus.icache_priv_i       = 2'b11;
        bus.mem_accept_i        = 1'b0;
        bus.mem_valid_i         = 1'b0;
        bus.mem_data_i          = '0;
        bus.mem_error_i         = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_accept", 64'(bus.icache_accept_o), 64'd0);
        check("rst_valid", 64'(bus.icache_valid_o), 64'd0);
        check("rst_error", 64'(bus.icache_error_o), 64'd0);
        check("rst_inst", bus.icache_inst_o, 64'd0);
        check("rst_pf", 64'(bus.icache_page_fault_o), 64'd0);
        check("rst_mem_rd", 64'(bus.mem_rd_o), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        rst = 1'b0;

        // 1: cold miss, response is beat 1
        miss_req("cold", 32'h8000_0008, 32'h8000_0000);
        fill(DA, -1);
        check_resp("cold_resp", DA + 64'd1, 1'b0);
        check("cold_idle_mem_rd", 64'(bus.mem_rd_o), 64'd0);

        // 2: back-to-back hits on the installed line
        bus.icache_rd_i = 1'b1;
        bus.icache_pc_i = 32'h8000_0000;
        #1;
        check("hit0_accept", 64'(bus.icache_accept_o), 64'd1);
        tick();
        bus.icache_pc_i = 32'h8000_0010;
        #1;
        check("hit0_valid", 64'(bus.icache_valid_o), 64'd1);
        check("hit0_inst", bus.icache_inst_o, DA);
        check("hit1_accept", 64'(bus.icache_accept_o), 64'd1);
        tick();
        bus.icache_pc_i = 32'h8000_0018;
        #1;
        check("hit1_valid", 64'(bus.icache_valid_o), 64'd1);
        check("hit1_inst", bus.icache_inst_o, DA + 64'd2);
        check("hit2_accept", 64'(bus.icache_accept_o), 64'd1);
        tick();
        bus.icache_rd_i = 1'b0;
        #1;
        check("hit2_valid", 64'(bus.icache_valid_o), 64'd1);
        check("hit2_inst", bus.icache_inst_o, DA + 64'd3);
        check("hit2_error", 64'(bus.icache_error_o), 64'd0);
        check("hits_no_mem_rd", 64'(bus.mem_rd_o), 64'd0);
        tick();
        check("hits_valid_end", 64'(bus.icache_valid_o), 64'd0);

        // 3: conflict miss evicts line 0, then the original pc misses again
        miss_req("conf", 32'h8000_0080, 32'h8000_0080);
        fill(DB, -1);
        check_resp("conf_resp", DB, 1'b0);
        miss_req("conf_re", 32'h8000_0000, 32'h8000_0000);
        fill(DA, -1);
        check_resp("conf_re_resp", DA, 1'b0);

        // 4: error on beat 2 -> error response, line not installed
        miss_req("err", 32'h8000_0040, 32'h8000_0040);
        fill(DC, 2);
        check_resp("err_resp", 64'd0, 1'b1);
        miss_req("err_retry", 32'h8000_0040, 32'h8000_0040);
        fill(DC, -1);
        check_resp("err_retry_resp", DC, 1'b0);

        // 5: flush during fill after beat 1; response still delivered, line dropped
        miss_req("fl", 32'h8000_0028, 32'h8000_0020);
        bus.mem_accept_i = 1'b1;
        tick();
        bus.mem_accept_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.mem_valid_i = 1'b1;
            bus.mem_data_i  = DE + 64'(k);
            tick();
        end
        bus.mem_valid_i    = 1'b0;
        bus.icache_flush_i = 1'b1;
        tick();
        bus.icache_flush_i = 1'b0;
        for (int k = 2; k < 4; k++) begin
            bus.mem_valid_i = 1'b1;
            bus.mem_data_i  = DE + 64'(k);
            tick();
        end
        bus.mem_valid_i = 1'b0;
        #1;
        check_resp("fl_resp", DE + 64'd1, 1'b0);
        miss_req("fl_retry", 32'h8000_0028, 32'h8000_0020);
        fill(DE, -1);
        check_resp("fl_retry_resp", DE + 64'd1, 1'b0);

        // 6: invalidate with rd in the same cycle -> not accepted, all lines cleared
        bus.icache_rd_i         = 1'b1;
        bus.icache_pc_i         = 32'h8000_0028;
        bus.icache_invalidate_i = 1'b1;
        #1;
        check("inv_accept", 64'(bus.icache_accept_o), 64'd0);
        tick();
        bus.icache_invalidate_i = 1'b0;
        bus.icache_rd_i         = 1'b0;
        #1;
        check("inv_no_valid", 64'(bus.icache_valid_o), 64'd0);
        check("inv_no_mem_rd", 64'(bus.mem_rd_o), 64'd0);
        miss_req("inv_miss", 32'h8000_0028, 32'h8000_0020);
        // reset while in REQ
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstreq_mem_rd", 64'(bus.mem_rd_o), 64'd0);
        check("rstreq_valid", 64'(bus.icache_valid_o), 64'd0);
        // previously installed line 0x80000000 must be gone after reset
        miss_req("rst_miss", 32'h8000_0000, 32'h8000_0000);
        // stray beat in REQ is ignored
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = 64'hDEAD;
        tick();
        bus.mem_valid_i = 1'b0;
        #1;
        check("stray_mem_rd", 64'(bus.mem_rd_o), 64'd1);
        check("stray_valid", 64'(bus.icache_valid_o), 64'd0);
        fill(DA, -1);
        check_resp("rst_miss_resp", DA, 1'b0);

        // PC wrap line is an ordinary line
        miss_req("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFE0);
        fill(DF, -1);
        check_resp("wrap_resp", DF + 64'd3, 1'b0);
        bus.icache_rd_i = 1'b1;
        bus.icache_pc_i = 32'hFFFF_FFE8;
        tick();
        bus.icache_rd_i = 1'b0;
        #1;
        check("wrap_hit_valid", 64'(bus.icache_valid_o), 64'd1);
        check("wrap_hit_inst", bus.icache_inst_o, DF + 64'd1);
        check("wrap_hit_mem_rd", 64'(bus.mem_rd_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
